lc2k_fetch_unit: RTL and testbench

//  Instruction fetch stage downstream of the LC2K next-PC select logic. Holds the architectural PC,

---
 rtl/lc2k_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_lc2k_fetch_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/lc2k_fetch_unit.sv
// LC2K fetch: holds PC, one imem read outstanding, word+PC to decode; `LC2K_FETCH_HALT_DET_EN adds halt stop.
// Latency: accept at N, response at N+1 earliest, instr_valid at N+2; a redirect kills held/in-flight work.
// Backpressure: req held until imem_req_ready; instr held while !instr_ready; no new fetch until consumed.
module lc2k_fetch_unit #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [PC_W-1:0] instr_pc,
    output logic [PC_W-1:0] pc_plus_one,
    output logic            halted
);

`ifdef LC2K_FETCH_HALT_DET_EN
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, HALTED} state_t;
`else
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
`endif

    state_t          state, nextState;
    logic [PC_W-1:0] pc;
    logic            drop;
    logic            instrValid;
    logic [31:0]     instrReg;
    logic [PC_W-1:0] instrPcReg;
    logic [PC_W-1:0] pcPlusOneReg;

    logic loadInstr, pcInc, pcRedir, setDrop, clrDrop, clrValid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        loadInstr = 1'b0;
        pcInc     = 1'b0;
        pcRedir   = 1'b0;
        setDrop   = 1'b0;
        clrDrop   = 1'b0;
        clrValid  = 1'b0;
        case (state)
            IDLE: nextState = ISSUE;
            ISSUE: begin
                pcRedir = redirect_valid;
                if (imem_req_ready) begin
                    // Accepted in the redirect cycle: the read is live, so its response must be dropped.
                    nextState = WAIT;
                    setDrop   = redirect_valid;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pcRedir = 1'b1;
                    if (imem_rsp_valid) begin
                        nextState = ISSUE;
                        clrDrop   = 1'b1;
                    end else begin
                        setDrop = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (drop) begin
                        clrDrop   = 1'b1;
                        nextState = ISSUE;
                    end else begin
                        loadInstr = 1'b1;
                        nextState = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pcRedir   = 1'b1;
                    clrValid  = 1'b1;
                    nextState = ISSUE;
                end else if (instr_ready) begin
                    clrValid  = 1'b1;
`ifdef LC2K_FETCH_HALT_DET_EN
                    if (instrReg[24:22] == 3'b110) begin
                        nextState = HALTED;
                    end else begin
                        pcInc     = 1'b1;
                        nextState = ISSUE;
                    end
`else
                    pcInc     = 1'b1;
                    nextState = ISSUE;
`endif
                end
            end
            default: nextState = state;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            drop         <= 1'b0;
            instrValid   <= 1'b0;
            instrReg     <= '0;
            instrPcReg   <= '0;
            pcPlusOneReg <= PC_W'(1);
        end else begin
            if (pcRedir)    pc <= redirect_pc;
            else if (pcInc) pc <= pc + PC_W'(1);

            if (setDrop)      drop <= 1'b1;
            else if (clrDrop) drop <= 1'b0;

            if (loadInstr) begin
                instrValid   <= 1'b1;
                instrReg     <= imem_rsp_data;
                instrPcReg   <= pc;
                pcPlusOneReg <= pc + PC_W'(1);
            end else if (clrValid) begin
                instrValid <= 1'b0;
            end
        end
    end

    assign imem_req_valid = (state == ISSUE);
    assign imem_addr      = pc;
    assign instr_valid    = instrValid;
    assign instr          = instrReg;
    assign instr_pc       = instrPcReg;
    assign pc_plus_one    = pcPlusOneReg;
`ifdef LC2K_FETCH_HALT_DET_EN
    assign halted = (state == HALTED);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_lc2k_fetch_unit.sv
// Directed-vector bench for lc2k_fetch_unit: one table row per clock cycle, plus wrap and halt sequences.
module tb_lc2k_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [15:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [15:0] instr_pc;
    logic [15:0] pc_plus_one;
    logic        halted;

    lc2k_fetch_unit #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .pc_plus_one(pc_plus_one), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [15:0] rpc;
        logic        rqr;
        logic        rsv;
        logic [31:0] rsd;
        logic        ir;
        logic        eReq;
        logic [15:0] eAddr;
        logic        eIv;
        logic [31:0] eInstr;
        logic [15:0] ePc;
        logic [15:0] ePpo;
        logic        eHalt;
    } vec_t;

    int nChecks = 0;
    int nPass   = 0;
    vec_t tbl[$];

    function automatic logic [31:0] memWord(input logic [15:0] a);
        return 32'hC0DE_0000 | {16'h0000, a};
    endfunction

    function automatic vec_t mk(input logic rv, input logic [15:0] rpc, input logic rqr,
                                input logic rsv, input logic [31:0] rsd, input logic ir,
                                input logic eReq, input logic [15:0] eAddr, input logic eIv,
                                input logic [31:0] eInstr, input logic [15:0] ePc,
                                input logic [15:0] ePpo, input logic eHalt);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.rqr = rqr; v.rsv = rsv; v.rsd = rsd; v.ir = ir;
        v.eReq = eReq; v.eAddr = eAddr; v.eIv = eIv; v.eInstr = eInstr;
        v.ePc = ePc; v.ePpo = ePpo; v.eHalt = eHalt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Drive one cycle's inputs at the falling edge, check registered outputs, then clock.
    task automatic applyVec(input vec_t v, input string tag);
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        imem_req_ready = v.rqr;
        imem_rsp_valid = v.rsv;
        imem_rsp_data  = v.rsd;
        instr_ready    = v.ir;
        #1;
        chk({tag, " req_valid"}, {31'd0, imem_req_valid}, {31'd0, v.eReq});
        if (v.eReq) chk({tag, " imem_addr"}, {16'd0, imem_addr}, {16'd0, v.eAddr});
        chk({tag, " instr_valid"}, {31'd0, instr_valid}, {31'd0, v.eIv});
        if (v.eIv) begin
            chk({tag, " instr"}, instr, v.eInstr);
            chk({tag, " instr_pc"}, {16'd0, instr_pc}, {16'd0, v.ePc});
            chk({tag, " pc_plus_one"}, {16'd0, pc_plus_one}, {16'd0, v.ePpo});
        end
        chk({tag, " halted"}, {31'd0, halted}, {31'd0, v.eHalt});
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 16'h0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        instr_ready = 1'b0;

        //          rv rpc       rqr rsv rsd            ir  | req addr     iv instr          pc        ppo      halt
        tbl.push_back(mk(0, 16'h0,  0, 0, 32'h0,          0,  0, 16'h0,  0, 32'h0,         16'h0,  16'h0,  0)); // IDLE
        tbl.push_back(mk(0, 16'h0,  1, 0, 32'h0,          0,  1, 16'h0,  0, 32'h0,         16'h0,  16'h0,  0));
        tbl.push_back(mk(0, 16'h0,  0, 1, memWord(16'h0), 0,  0, 16'h0,  0, 32'h0,         16'h0,  16'h0,  0));
        tbl.push_back(mk(0, 16'h0,  0, 0, 32'h0,          1,  0, 16'h0,  1, memWord(16'h0), 16'h0, 16'h1,  0));
        tbl.push_back(mk(0, 16'h0,  1, 0, 32'h0,          0,  1, 16'h1,  0, 32'h0,         16'h0,  16'h0,  0));
        tbl.push_back(mk(0, 16'h0,  0, 1, memWord(16'h1), 0,  0, 16'h0,  0, 32'h0,         16'h0,  16'h0,  0));
        tbl.push_back(mk(0, 16'h0,  0, 0, 32'h0,          1,  0, 16'h0,  1, memWord(16'h1), 16'h1, 16'h2,  0));
        tbl.push_back(mk(0, 16'h0,  1, 0, 32'h0,          0,  1, 16'h2,  0, 32'h0,         16'h0,  16'h0,  0));
        tbl.push_back(mk(0, 16'h0,  0, 1, memWord(16'h2), 0,  0, 16'h0,  0, 32'h0,         16'h0,  16'h0,  0));
        for (int i = 0; i < 5; i++)  // decode stalls: word at pc 2 held, no new request
            tbl.push_back(mk(0, 16'h0, 1, 0, 32'h0, 0,    0, 16'h0,  1, memWord(16'h2), 16'h2, 16'h3,  0));
        tbl.push_back(mk(0, 16'h0,  0, 0, 32'h0,          1,  0, 16'h0,  1, memWord(16'h2), 16'h2, 16'h3,  0));
        tbl.push_back(mk(0, 16'h0,  0, 0, 32'h0,          0,  1, 16'h3,  0, 32'h0,         16'h0,  16'h0,  0)); // imem stalls
        tbl.push_back(mk(0, 16'h0,  1, 0, 32'h0,          0,  1, 16'h3,  0, 32'h0,         16'h0,  16'h0,  0));
        tbl.push_back(mk(0, 16'h0,  0, 0, 32'h0,          0,  0, 16'h0,  0, 32'h0,         16'h0,  16'h0,  0)); // 2-cycle rsp
        tbl.push_back(mk(0, 16'h0,  0, 1, memWord(16'h3), 0,  0, 16'h0,  0, 32'h0,         16'h0,  16'h0,  0));
        tbl.push_back(mk(1, 16'h10, 0, 0, 32'h0,          1,  0, 16'h0,  1, memWord(16'h3), 16'h3, 16'h4,  0)); // redirect+consume
        tbl.push_back(mk(0, 16'h0,  1, 0, 32'h0,          0,  1, 16'h10, 0, 32'h0,         16'h0,  16'h0,  0));
        tbl.push_back(mk(0, 16'h0,  0, 1, memWord(16'h10),0,  0, 16'h0,  0, 32'h0,         16'h0,  16'h0,  0));
        tbl.push_back(mk(0, 16'h0,  0, 0, 32'h0,          1,  0, 16'h0,  1, memWord(16'h10),16'h10, 16'h11, 0));
        tbl.push_back(mk(1, 16'h5,  0, 0, 32'h0,          0,  1, 16'h11, 0, 32'h0,         16'h0,  16'h0,  0)); // withdraw
        tbl.push_back(mk(0, 16'h0,  1, 0, 32'h0,          0,  1, 16'h5,  0, 32'h0,         16'h0,  16'h0,  0));
        tbl.push_back(mk(1, 16'h40, 0, 0, 32'h0,          0,  0, 16'h0,  0, 32'h0,         16'h0,  16'h0,  0)); // redirect in WAIT
        tbl.push_back(mk(0, 16'h0,  0, 1, memWord(16'h5), 1,  0, 16'h0,  0, 32'h0,         16'h0,  16'h0,  0)); // dropped
        tbl.push_back(mk(0, 16'h0,  1, 0, 32'h0,          1,  1, 16'h40, 0, 32'h0,         16'h0,  16'h0,  0));
        tbl.push_back(mk(0, 16'h0,  0, 1, memWord(16'h40),0,  0, 16'h0,  0, 32'h0,         16'h0,  16'h0,  0));
        tbl.push_back(mk(0, 16'h0,  0, 0, 32'h0,          1,  0, 16'h0,  1, memWord(16'h40),16'h40, 16'h41, 0));
        tbl.push_back(mk(1, 16'h20, 1, 0, 32'h0,          0,  1, 16'h41, 0, 32'h0,         16'h0,  16'h0,  0)); // accept+redirect
        tbl.push_back(mk(0, 16'h0,  0, 1, memWord(16'h41),1,  0, 16'h0,  0, 32'h0,         16'h0,  16'h0,  0)); // dropped
        tbl.push_back(mk(0, 16'h0,  0, 0, 32'h0,          0,  1, 16'h20, 0, 32'h0,         16'h0,  16'h0,  0));

        repeat (2) @(negedge clk);
        #1;
        chk("reset req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("reset instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("reset imem_addr", {16'd0, imem_addr}, 32'd0);
        chk("reset instr", instr, 32'd0);
        chk("reset instr_pc", {16'd0, instr_pc}, 32'd0);
        chk("reset pc_plus_one", {16'd0, pc_plus_one}, 32'd1);
        chk("reset halted", {31'd0, halted}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            applyVec(tbl[i], $sformatf("row%0d", i));

        // PC wrap: redirect to the top word, consume it, next fetch must be word 0.
        applyVec(mk(1, 16'hFFFF, 0, 0, 32'h0, 0, 1, 16'h20, 0, 32'h0, 16'h0, 16'h0, 0), "wrap0");
        applyVec(mk(0, 16'h0, 1, 0, 32'h0, 0, 1, 16'hFFFF, 0, 32'h0, 16'h0, 16'h0, 0), "wrap1");
        applyVec(mk(0, 16'h0, 0, 1, memWord(16'hFFFF), 0, 0, 16'h0, 0, 32'h0, 16'h0, 16'h0, 0), "wrap2");
        applyVec(mk(0, 16'h0, 0, 0, 32'h0, 1, 0, 16'h0, 1, memWord(16'hFFFF), 16'hFFFF, 16'h0000, 0), "wrap3");
        applyVec(mk(0, 16'h0, 0, 0, 32'h0, 0, 1, 16'h0000, 0, 32'h0, 16'h0, 16'h0, 0), "wrap4");

        // Halt word at pc 7.
        applyVec(mk(1, 16'h7, 0, 0, 32'h0, 0, 1, 16'h0, 0, 32'h0, 16'h0, 16'h0, 0), "halt0");
        applyVec(mk(0, 16'h0, 1, 0, 32'h0, 0, 1, 16'h7, 0, 32'h0, 16'h0, 16'h0, 0), "halt1");
        applyVec(mk(0, 16'h0, 0, 1, 32'h0180_0000, 0, 0, 16'h0, 0, 32'h0, 16'h0, 16'h0, 0), "halt2");
        applyVec(mk(0, 16'h0, 0, 0, 32'h0, 1, 0, 16'h0, 1, 32'h0180_0000, 16'h7, 16'h8, 0), "halt3");
`ifdef LC2K_FETCH_HALT_DET_EN
        applyVec(mk(0, 16'h0, 1, 0, 32'h0, 1, 0, 16'h0, 0, 32'h0, 16'h0, 16'h0, 1), "halt4");
        applyVec(mk(1, 16'h30, 1, 0, 32'h0, 1, 0, 16'h0, 0, 32'h0, 16'h0, 16'h0, 1), "halt5");
        applyVec(mk(0, 16'h0, 1, 0, 32'h0, 1, 0, 16'h0, 0, 32'h0, 16'h0, 16'h0, 1), "halt6");
        rst_n = 1'b0;
        #1;
        chk("halt rst halted", {31'd0, halted}, 32'd0);
        chk("halt rst req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("halt rst pc_plus_one", {16'd0, pc_plus_one}, 32'd1);
`else
        applyVec(mk(0, 16'h0, 1, 0, 32'h0, 0, 1, 16'h8, 0, 32'h0, 16'h0, 16'h0, 0), "halt4");
        applyVec(mk(0, 16'h0, 0, 0, 32'h0, 0, 0, 16'h0, 0, 32'h0, 16'h0, 16'h0, 0), "halt5");
`endif

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
